// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the system-bus arbiter: FSM state encodings and
// requester index constants for the sequencer, program loader and debug port.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int REQ_SEQ    = 0;
  localparam int REQ_LOADER = 1;
  localparam int REQ_DEBUG  = 2;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: returns the first set req bit scanning
// upward from ptr_i with wrap-around, as one-hot and as an index.
module bus_rr_pick #(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] win_o,
  output logic [IDW-1:0]  win_id_o,
  output logic            any_o
);

  logic found;

  always_comb begin
    win_o    = '0;
    win_id_o = '0;
    found    = 1'b0;
    any_o    = |req_i;
    for (int k = 0; k < NREQ; k++) begin
      logic [IDW-1:0] sel;
      sel = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        win_id_o   = sel;
        win_o[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared 8-bit tri-state bus, with a dead turnaround cycle
// on every ownership change. Define BUS_ARB_WDOG_EN to bound ownership to HOLD_MAX cycles.
module bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter  int NREQ     = 3,
  parameter  int HOLD_MAX = 16,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] drive_en,
  output logic            busy,
  output logic [IDW-1:0]  owner_id,
  output logic            timeout,
  output logic            timeout_flag,
  output arb_state_t      dbg_state
);

  // Handshake: a requester raises req and holds it for its whole tenure; gnt
  // answers one cycle later, drive_en a cycle after that, and dropping req
  // hands the bus back with one dead cycle before anyone else may drive.

  if (NREQ < 2 || NREQ > 8 || HOLD_MAX < 1) begin : g_bad_params
    $error("bus_arbiter: NREQ must be 2..8 and HOLD_MAX at least 1");
  end

  arb_state_t      state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d, ptr_q, ptr_d, next_ptr, win_id;
  logic [NREQ-1:0] gnt_q, gnt_d, den_q, den_d, win;
  logic            busy_q, any_req, owner_req, release_now, hold_expired;

  bus_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .win_o    (win),
    .win_id_o (win_id),
    .any_o    (any_req)
  );

  assign owner_req = req[owner_q];
  assign next_ptr  = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // The pointer moves on the way into RELEASE, so the RELEASE cycle already
  // arbitrates with the post-owner pointer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    den_d       = den_q;
    release_now = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        state_d = IDLE;
        owner_d = '0;
        gnt_d   = '0;
        den_d   = '0;
        if (any_req) begin
          state_d = GRANT;
          owner_d = win_id;
          gnt_d   = win;
        end
      end
      GRANT: begin
        if (owner_req) begin
          state_d = OWN;
          den_d   = gnt_q;
        end else begin
          release_now = 1'b1;
        end
      end
      OWN:     release_now = !owner_req || hold_expired;
      default: state_d = IDLE;
    endcase
    if (release_now) begin
      state_d = RELEASE;
      owner_d = '0;
      gnt_d   = '0;
      den_d   = '0;
      ptr_d   = next_ptr;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      den_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      den_q   <= den_d;
      busy_q  <= |gnt_d;
    end
  end

`ifdef BUS_ARB_WDOG_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d, flag_q, flag_d;

  // hold_q counts completed OWN cycles; the HOLD_MAX-th OWN cycle is the last.
  assign hold_expired = (hold_q == HW'(HOLD_MAX - 1));

  always_comb begin
    hold_d    = hold_q;
    timeout_d = 1'b0;
    flag_d    = flag_q;
    if (state_q == GRANT) begin
      hold_d = '0;
    end else if (state_q == OWN) begin
      if (owner_req && hold_expired) begin
        timeout_d = 1'b1;
        flag_d    = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      flag_q    <= flag_d;
    end
  end

  assign timeout      = timeout_q;
  assign timeout_flag = flag_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign drive_en  = den_q;
  assign busy      = busy_q;
  assign owner_id  = owner_q;
  assign dbg_state = state_q;

endmodule
